ir_con_shaper: RTL and testbench
================================

// Module: ir_con_shaper
// PURPOSE
//  Parametrised store-and-forward rate shaper on the TX frame-FIFO word stream (36-bit words).
//  Buffers whole frames, releases them under a token-bucket credit limit set over the up bus.
//  Drops frames that overflow the buffer. Sits between the TX frame generator and the frame FIFO.
// PARAMETERS
//  DATA_W    32        payload bits per word; word = {ctrl[3:0], data[DATA_W-1:0]}
//  FIFO_AW   9         buffer address bits; depth 2**FIFO_AW words
//  CREDIT_W  24        signed credit accumulator width; units 1/256 word
//  BASE_ADDR 32'h0     up-bus base address; decode on up_addr[31:5]
// PORTS
//  clk                 in   1         single clock; up bus is synchronous to clk
//  rst                 in   1         asynchronous, active-high reset
//  test_start          in   1         high = run; low = flush and idle
//  up_wr               in   1         single-cycle register write strobe
//  up_rd               in   1         single-cycle register read strobe
//  up_addr             in   32        byte address
//  up_data_wr          in   32        write data
//  up_data_rd          out  32        read data, valid the cycle after up_rd
//  frame_fifo_wr_in    in   1         input word valid; no back-pressure
//  frame_fifo_data_in  in   DATA_W+4  [DATA_W+3]=sop, [DATA_W+2]=eop, [DATA_W+1:DATA_W]=ctrl, rest data
//  frame_fifo_wr_out   out  1         output word valid
//  frame_fifo_data_out out  DATA_W+4  output word, same format
// BEHAVIOUR
//  Reset: all outputs 0; pointers, credit, counters 0; CTRL=0, RATE=0, BURST=0; FSM IDLE.
//  Registers (offset): 0x00 CTRL rw [0]=shape_en [1]=bypass; 0x04 RATE rw [15:0] credit/cycle;
//   0x08 BURST rw [CREDIT_W-2:0] credit cap; 0x0C DROP_CNT ro, any write clears; 0x10 TX_FRAMES ro, write clears.
//   Unmapped/other-base read returns 0; up_data_rd is 0 in every cycle not following up_rd.
//  test_start low: buffer flushed (all pointers/frame count 0), input ignored and not counted,
//   FSM forced IDLE, credit 0, outputs 0. Registers and counters keep values.
//  Bypass (CTRL[1]=1): output = input delayed exactly 1 cycle; buffer flushed; credit frozen.
//   Changing bypass takes effect only while FSM IDLE and no input frame open.
//  Write side: word with sop starts frame at wr_ptr (start saved); words written while frame open;
//   eop word commits: commit_ptr <= wr_ptr+1, frame count +1. sop+eop same word = 1-word frame.
//  Full = (wr_ptr+1)==rd_ptr. Word arriving when full: wr_ptr rewound to frame start, rest of
//   frame discarded until next sop, DROP_CNT +1 (saturating 32b). Frames > depth-1 always drop.
//  sop while frame open: partial frame rewound, DROP_CNT +1, new frame starts. Non-sop word with
//   no frame open: discarded, not counted.
//  Read FSM: IDLE -> SEND when frame count>0 and (shape_en==0 or credit>=0); SEND reads one word
//   per cycle (RAM read latency 1, output registered) until eop word emitted -> IDLE.
//   Frames are never split or throttled mid-frame. TX_FRAMES +1 per emitted eop.
//  Latency: eop written cycle T -> sop out at T+3 earliest (credit permitting); back-to-back
//   committed frames leave one idle output cycle between eop and next sop.
//  Credit (shape_en=1), every cycle: credit <= min(credit + RATE - (wr_out ? 256 : 0), BURST),
//   saturate low at -2**(CREDIT_W-1). shape_en=0: credit held at 0, frames released immediately.
//  Commit and release in same cycle: frame count unchanged. Pointers wrap modulo depth.
//  rst mid-frame: everything to reset values; partial output frame is truncated (no eop).
// TESTING
//  shape_en=0, 3 frames of 4 words -> out identical order/data, sop at eop_in+3, DROP_CNT=0.
//  RATE=64, BURST=0, 10-word frames back-to-back -> each frame starts ~40 cycles after prior start.
//  FIFO_AW=4, 20-word frame -> no output, DROP_CNT=1; next 5-word frame passes intact.
//  sop, 3 words, sop (no eop), 4-word frame -> only 4-word frame out, DROP_CNT=1.
//  bypass=1, random stream -> out equals in delayed 1 cycle, buffer empty.
//  test_start low mid-frame then high -> outputs 0, no partial frame ever emitted; read 0x0C after
//   up_rd returns count next cycle, write 0x0C -> reads 0.

Source files
------------

// File: rtl/ir_con_shaper_if.sv
// Up-bus register port and frame-FIFO word streams for ir_con_shaper.
interface ir_con_shaper_if #(
  parameter int unsigned DATA_W = 32
) ();
  logic              up_wr;
  logic              up_rd;
  logic [31:0]       up_addr;
  logic [31:0]       up_data_wr;
  logic [31:0]       up_data_rd;
  logic              frame_fifo_wr_in;
  logic [DATA_W+3:0] frame_fifo_data_in;
  logic              frame_fifo_wr_out;
  logic [DATA_W+3:0] frame_fifo_data_out;

  modport master (
    output up_wr, up_rd, up_addr, up_data_wr, frame_fifo_wr_in, frame_fifo_data_in,
    input  up_data_rd, frame_fifo_wr_out, frame_fifo_data_out
  );

  modport slave (
    input  up_wr, up_rd, up_addr, up_data_wr, frame_fifo_wr_in, frame_fifo_data_in,
    output up_data_rd, frame_fifo_wr_out, frame_fifo_data_out
  );
endinterface

// File: rtl/ir_con_shaper.sv
// Store-and-forward token-bucket rate shaper for the TX frame-FIFO word stream.
// Whole frames are buffered and released under a credit limit; overflowing frames are dropped.
module ir_con_shaper #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned FIFO_AW   = 9,
  parameter int unsigned CREDIT_W  = 24,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           test_start,
  ir_con_shaper_if.slave bus
);
  localparam int unsigned W     = DATA_W + 4;
  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam int unsigned CW    = CREDIT_W + 2;
  localparam int unsigned SOP   = W - 1;
  localparam int unsigned EOP   = W - 2;

  typedef enum logic {IDLE, SEND} state_t;
  typedef logic [FIFO_AW-1:0] ptr_t;

  logic [1:0]          ctrl;
  logic [15:0]         rate;
  logic [CREDIT_W-2:0] burst;
  logic [31:0]         drop_cnt, tx_frames, rd_mux, up_data_rd_q;
  logic [32:0]         drop_sum;
  logic                hit, shape_en;

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] in_word, ram_q, data_out_q;
  logic         in_sop, in_eop, ram_v, wr_out_q;
  ptr_t         wr_ptr, rd_ptr, commit_ptr, frm_start, frame_cnt;
  logic         frame_open, in_frame, bypass_act, run;

  ptr_t         pos, wr_addr, wr_ptr_n, frm_start_n;
  logic         wr_en, frame_open_n, commit;
  logic [1:0]   drop_inc;

  state_t       state, state_n;
  logic         rd_en, release_frm, go, tx_eop;

  logic signed [CREDIT_W-1:0] credit;
  logic signed [CW-1:0]       c_ext, r_ext, cost, sum, cap, floor_v, credit_nx;

  assign in_word  = bus.frame_fifo_data_in;
  assign in_sop   = in_word[SOP];
  assign in_eop   = in_word[EOP];
  assign shape_en = ctrl[0];
  assign run      = test_start && !bypass_act;
  assign hit      = (bus.up_addr[31:5] == BASE_ADDR[31:5]);
  assign tx_eop   = run && ram_v && ram_q[EOP];

  assign bus.up_data_rd          = up_data_rd_q;
  assign bus.frame_fifo_wr_out   = wr_out_q;
  assign bus.frame_fifo_data_out = data_out_q;

  always_comb begin
    rd_mux = '0;
    case (bus.up_addr[4:0])
      5'h00:   rd_mux = {30'd0, ctrl};
      5'h04:   rd_mux = {16'd0, rate};
      5'h08:   rd_mux = 32'(burst);
      5'h0C:   rd_mux = drop_cnt;
      5'h10:   rd_mux = tx_frames;
      default: rd_mux = '0;
    endcase
  end

  assign drop_sum = {1'b0, drop_cnt} + 33'(drop_inc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl         <= '0;
      rate         <= '0;
      burst        <= '0;
      drop_cnt     <= '0;
      tx_frames    <= '0;
      up_data_rd_q <= '0;
    end else begin
      up_data_rd_q <= (bus.up_rd && hit) ? rd_mux : '0;
      if (bus.up_wr && hit) begin
        case (bus.up_addr[4:0])
          5'h00:   ctrl  <= bus.up_data_wr[1:0];
          5'h04:   rate  <= bus.up_data_wr[15:0];
          5'h08:   burst <= bus.up_data_wr[CREDIT_W-2:0];
          default: ;
        endcase
      end
      if (bus.up_wr && hit && bus.up_addr[4:0] == 5'h0C)
        drop_cnt <= '0;
      else
        drop_cnt <= drop_sum[32] ? '1 : drop_sum[31:0];
      if (bus.up_wr && hit && bus.up_addr[4:0] == 5'h10)
        tx_frames <= '0;
      else if (tx_eop)
        tx_frames <= tx_frames + 32'd1;
    end
  end

  // Write side: an open frame is rewound to its start on overflow or on a fresh sop,
  // so only committed (eop-terminated) frames are ever visible to the reader.
  always_comb begin
    pos          = wr_ptr;
    wr_en        = 1'b0;
    wr_addr      = wr_ptr;
    wr_ptr_n     = wr_ptr;
    frm_start_n  = frm_start;
    frame_open_n = frame_open;
    commit       = 1'b0;
    drop_inc     = '0;
    if (run && bus.frame_fifo_wr_in) begin
      if (in_sop) begin
        pos = frame_open ? frm_start : wr_ptr;
        if (frame_open) drop_inc = 2'd1;
        if (ptr_t'(pos + ptr_t'(1)) == rd_ptr) begin
          drop_inc     = drop_inc + 2'd1;
          wr_ptr_n     = pos;
          frame_open_n = 1'b0;
        end else begin
          wr_en        = 1'b1;
          wr_addr      = pos;
          wr_ptr_n     = pos + ptr_t'(1);
          frm_start_n  = pos;
          frame_open_n = !in_eop;
          commit       = in_eop;
        end
      end else if (frame_open) begin
        if (ptr_t'(wr_ptr + ptr_t'(1)) == rd_ptr) begin
          drop_inc     = 2'd1;
          wr_ptr_n     = frm_start;
          frame_open_n = 1'b0;
        end else begin
          wr_en        = 1'b1;
          wr_ptr_n     = wr_ptr + ptr_t'(1);
          frame_open_n = !in_eop;
          commit       = in_eop;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= in_word;
    if (rd_en) ram_q <= mem[rd_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      commit_ptr <= '0;
      frm_start  <= '0;
      frame_cnt  <= '0;
      frame_open <= 1'b0;
    end else if (!run) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      commit_ptr <= '0;
      frm_start  <= '0;
      frame_cnt  <= '0;
      frame_open <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_n;
      frm_start  <= frm_start_n;
      frame_open <= frame_open_n;
      if (commit) commit_ptr <= wr_ptr_n;
      if (rd_en) rd_ptr <= rd_ptr + ptr_t'(1);
      case ({commit, release_frm})
        2'b10:   frame_cnt <= frame_cnt + ptr_t'(1);
        2'b01:   frame_cnt <= frame_cnt - ptr_t'(1);
        default: ;
      endcase
    end
  end

  // Raw input framing, used only to hold bypass changes until a frame boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_frame   <= 1'b0;
      bypass_act <= 1'b0;
    end else begin
      if (!test_start)
        in_frame <= 1'b0;
      else if (bus.frame_fifo_wr_in) begin
        if (in_eop)      in_frame <= 1'b0;
        else if (in_sop) in_frame <= 1'b1;
      end
      if (state == IDLE && !rd_en && !in_frame)
        bypass_act <= ctrl[1];
    end
  end

  // Shaped release also waits for the last output word so its charge is already in credit.
  always_comb begin
    state_n     = state;
    rd_en       = 1'b0;
    release_frm = 1'b0;
    go = (frame_cnt != '0) && (!shape_en || (!credit[CREDIT_W-1] && !wr_out_q));
    if (!run) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: if (go) begin
          rd_en       = 1'b1;
          release_frm = 1'b1;
          state_n     = SEND;
        end
        SEND: begin
          if (ram_v && ram_q[EOP]) state_n = IDLE;
          else                     rd_en   = (rd_ptr != commit_ptr);
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ram_v      <= 1'b0;
      wr_out_q   <= 1'b0;
      data_out_q <= '0;
    end else begin
      state <= state_n;
      ram_v <= rd_en;
      if (!test_start) begin
        wr_out_q   <= 1'b0;
        data_out_q <= '0;
      end else if (bypass_act) begin
        wr_out_q   <= bus.frame_fifo_wr_in;
        data_out_q <= in_word;
      end else begin
        wr_out_q   <= ram_v;
        data_out_q <= ram_v ? ram_q : '0;
      end
    end
  end

  always_comb begin
    c_ext   = {{2{credit[CREDIT_W-1]}}, credit};
    r_ext   = {{(CW-16){1'b0}}, rate};
    cost    = wr_out_q ? CW'(256) : '0;
    cap     = {3'b000, burst};
    floor_v = {3'b111, {(CREDIT_W-1){1'b0}}};
    sum     = c_ext + r_ext - cost;
    if (sum > cap)          credit_nx = cap;
    else if (sum < floor_v) credit_nx = floor_v;
    else                    credit_nx = sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      credit <= '0;
    else if (!test_start || !shape_en)
      credit <= '0;
    else if (!bypass_act)
      credit <= credit_nx[CREDIT_W-1:0];
  end
endmodule

// File: tb/tb_ir_con_shaper.sv
// Directed bench for ir_con_shaper: ordering, latency, shaping, drops, flush and bypass.
module tb_ir_con_shaper;
  localparam int unsigned DW = 32;
  localparam int unsigned W  = DW + 4;

  logic clk;
  logic rst;
  logic test_start;

  ir_con_shaper_if #(.DATA_W(DW)) bus ();

  ir_con_shaper #(.DATA_W(DW), .FIFO_AW(4), .CREDIT_W(24), .BASE_ADDR(32'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .test_start (test_start),
    .bus        (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [W-1:0] out_q[$];
  logic [W-1:0] exp_q[$];
  int           out_t[$];
  int           eop_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (bus.frame_fifo_wr_out === 1'b1) begin
      out_q.push_back(bus.frame_fifo_data_out);
      out_t.push_back(cyc);
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic up_write(input logic [31:0] a, input logic [31:0] d);
    bus.up_addr = a; bus.up_data_wr = d; bus.up_wr = 1'b1;
    tick(1);
    bus.up_wr = 1'b0;
  endtask

  task automatic up_read(input logic [31:0] a, output logic [31:0] d);
    bus.up_addr = a; bus.up_rd = 1'b1;
    tick(1);
    bus.up_rd = 1'b0;
    d = bus.up_data_rd;
  endtask

  task automatic drive_word(input logic v, input logic [W-1:0] w);
    bus.frame_fifo_wr_in = v; bus.frame_fifo_data_in = w;
    tick(1);
    bus.frame_fifo_wr_in = 1'b0; bus.frame_fifo_data_in = '0;
  endtask

  task automatic send_frame(input int n, input logic [31:0] base, input bit with_eop, input bit keep);
    logic [W-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = {(i == 0), (with_eop && i == n - 1), 2'(i), base + 32'(i)};
      if (keep) exp_q.push_back(w);
      if (w[W-2]) eop_q.push_back(cyc);
      drive_word(1'b1, w);
    end
  endtask

  task automatic clear_q();
    out_q.delete(); exp_q.delete(); out_t.delete(); eop_q.delete();
  endtask

  task automatic check_out(input string tag);
    check(tag, 64'(out_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
      check(tag, 64'(out_q[i]), 64'(exp_q[i]));
  endtask

  initial begin
    logic [31:0]  rd;
    logic         v;
    logic [W-1:0] w;
    rst = 1'b1; test_start = 1'b0;
    bus.up_wr = 1'b0; bus.up_rd = 1'b0; bus.up_addr = '0; bus.up_data_wr = '0;
    bus.frame_fifo_wr_in = 1'b0; bus.frame_fifo_data_in = '0;
    repeat (2) @(negedge clk);
    check("rst_wr_out", 64'(bus.frame_fifo_wr_out), 0);
    check("rst_data_out", 64'(bus.frame_fifo_data_out), 0);
    check("rst_up_rd", 64'(bus.up_data_rd), 0);
    tick(1);
    rst = 1'b0;
    tick(1);

    up_read(32'h00, rd); check("rst_ctrl", 64'(rd), 0);
    up_read(32'h04, rd); check("rst_rate", 64'(rd), 0);
    up_read(32'h08, rd); check("rst_burst", 64'(rd), 0);
    up_read(32'h0C, rd); check("rst_drop", 64'(rd), 0);
    up_read(32'h10, rd); check("rst_tx", 64'(rd), 0);
    up_write(32'h24, 32'h55);
    up_read(32'h04, rd); check("other_base", 64'(rd), 0);
    up_write(32'h08, 32'h7);
    up_read(32'h08, rd); check("burst_rw", 64'(rd), 7);
    up_write(32'h08, 32'h0);
    up_read(32'h14, rd); check("unmapped", 64'(rd), 0);

    test_start = 1'b1;
    tick(2);

    clear_q();
    send_frame(4, 32'h1000, 1, 1);
    send_frame(4, 32'h2000, 1, 1);
    send_frame(4, 32'h3000, 1, 1);
    tick(25);
    check_out("pass_data");
    if (out_t.size() >= 12) begin
      check("pass_lat", 64'(out_t[0] - eop_q[0]), 3);
      check("pass_gap1", 64'(out_t[4] - out_t[3]), 2);
      check("pass_gap2", 64'(out_t[8] - out_t[7]), 2);
    end
    up_read(32'h0C, rd); check("pass_drop", 64'(rd), 0);

    up_write(32'h04, 32'd64);
    up_write(32'h00, 32'h1);
    tick(3);
    clear_q();
    send_frame(10, 32'h4000, 1, 1);
    send_frame(10, 32'h5000, 1, 1);
    tick(75);
    check_out("rate_data");
    if (out_t.size() >= 20) begin
      check("rate_lat", 64'(out_t[0] - eop_q[0]), 3);
      check("rate_gap", 64'(out_t[10] - out_t[0]), 42);
    end
    up_write(32'h00, 32'h0);
    tick(3);

    clear_q();
    send_frame(20, 32'h6000, 1, 0);
    send_frame(5, 32'h7000, 1, 1);
    tick(25);
    check_out("ovf_data");
    up_read(32'h0C, rd); check("ovf_drop", 64'(rd), 1);
    clear_q();
    send_frame(15, 32'h7800, 1, 1);
    tick(30);
    check_out("max_frame");

    clear_q();
    send_frame(4, 32'h8000, 0, 0);
    send_frame(4, 32'h9000, 1, 1);
    tick(20);
    check_out("abort_data");
    up_read(32'h0C, rd); check("abort_drop", 64'(rd), 2);
    tick(1);
    check("rd_idle_zero", 64'(bus.up_data_rd), 0);
    up_write(32'h0C, 32'h0);
    up_read(32'h0C, rd); check("drop_clear", 64'(rd), 0);
    up_read(32'h10, rd); check("tx_frames", 64'(rd), 8);
    up_write(32'h10, 32'h0);
    up_read(32'h10, rd); check("tx_clear", 64'(rd), 0);

    clear_q();
    send_frame(2, 32'hA000, 0, 0);
    test_start = 1'b0;
    send_frame(3, 32'hA100, 1, 0);
    tick(10);
    check("ts_low_out", 64'(out_q.size()), 0);
    test_start = 1'b1;
    tick(2);
    drive_word(1'b1, {4'b0000, 32'hA200});
    drive_word(1'b1, {4'b0100, 32'hA201});
    send_frame(3, 32'hB000, 1, 1);
    tick(20);
    check_out("ts_data");
    up_read(32'h0C, rd); check("ts_drop", 64'(rd), 0);

    up_write(32'h00, 32'h2);
    tick(3);
    for (int i = 0; i < 20; i++) begin
      v = 1'($urandom_range(0, 1));
      w = {4'($urandom), $urandom};
      if (i == 19) begin v = 1'b1; w[W-2] = 1'b1; end
      drive_word(v, w);
      check("bypass", {27'd0, bus.frame_fifo_wr_out, bus.frame_fifo_data_out}, {27'd0, v, w});
    end
    up_write(32'h00, 32'h0);
    tick(4);
    clear_q();
    send_frame(2, 32'hC000, 1, 1);
    tick(15);
    check_out("post_bypass");
    if (out_t.size() >= 1) check("post_bypass_lat", 64'(out_t[0] - eop_q[0]), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
